// File: rtl/uart_pkg.sv
//==============================================================================
// Module      : uart_pkg
// Description : Shared state encoding and default word width for the UART
//               transmit arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        START = 2'b10,
        WAIT  = 2'b11
    } state_t;

    localparam int c_DATA_W_DEFAULT = 8;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
//==============================================================================
// Module      : rr_pick
// Description : Combinational rotating-priority search. Returns the first set
//               request bit at or above rr_ptr, wrapping past N_REQ-1 to 0.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic             found,
    output logic [PTR_W-1:0] idx
);

    // Scan from the farthest offset down so the nearest hit overwrites last.
    always_comb begin
        found = |req;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % N_REQ]) begin
                idx = PTR_W'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
//==============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter handing one requester word at a time to a
//               UART transmitter. Optional WAIT timeout: UART_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = c_DATA_W_DEFAULT,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           grant,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_start,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       timeout_err
);

    localparam int c_PTR_W = $clog2(N_REQ);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic [c_PTR_W-1:0]   r_owner;
    logic [DATA_W-1:0]    r_tx_data;
    logic [c_PTR_W-1:0]   w_idx;
    logic [c_PTR_W-1:0]   w_owner_inc;
    logic                 w_found;
    logic                 w_capture;
    logic                 w_advance;
    logic                 w_wait_expired;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (c_PTR_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .found  (w_found),
        .idx    (w_idx)
    );

    assign w_owner_inc = (r_owner == c_PTR_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        grant       = '0;
        tx_start    = 1'b0;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = LOAD;
                    w_capture   = 1'b1;
                end
            end
            LOAD: begin
                grant[r_owner] = 1'b1;
                w_state_nxt    = START;
            end
            START: begin
                tx_start    = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // A timeout releases the channel exactly like a completion.
                if (tx_done || w_wait_expired) begin
                    w_state_nxt = IDLE;
                    w_advance   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_tx_data <= '0;
        end else begin
            if (w_capture) begin
                r_owner   <= w_idx;
                r_tx_data <= req_data[int'(w_idx)*DATA_W +: DATA_W];
            end
            if (w_advance) begin
                r_rr_ptr <= w_owner_inc;
            end
        end
    end

    assign tx_data = r_tx_data;
    assign owner   = r_owner;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_timeout_err;

    // Counter holds the index of the current WAIT cycle; tx_done wins a tie.
    assign w_wait_expired = (r_state == WAIT) && (r_wait_cnt == c_CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_wait_expired && !tx_done;
            if (r_state == START) begin
                r_wait_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_wait_expired = 1'b0;
    assign timeout_err    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//==============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter with a
//               grant/tx_start scoreboard; timeout steps need UART_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [31:0] req_data;
    logic        tx_done = 1'b0;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        busy;
    logic [1:0]  owner;
    logic        timeout_err;

    typedef struct {
        int         owner;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    uart_tx_arbiter #(
        .N_REQ       (4),
        .DATA_W      (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .busy        (busy),
        .owner       (owner),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int o);
        exp_t e;
        e.owner = o;
        e.data  = req_data[o*8 +: 8];
        sb.push_back(e);
    endtask

    // One full transfer starting from IDLE with req already driven.
    task automatic xfer(input int exp_owner, input logic [3:0] req_after,
                        input logic [31:0] data_after, input int done_delay,
                        input bit done_in_start);
        tick;
        check("grant", {28'd0, grant}, 32'(1) << exp_owner);
        check("owner", {30'd0, owner}, exp_owner);
        check("busy_load", {31'd0, busy}, 1);
        req      = req_after;
        req_data = data_after;
        tick;
        check("tx_start", {31'd0, tx_start}, 1);
        check("grant_width", {28'd0, grant}, 0);
        if (done_in_start) tx_done = 1'b1;
        repeat (done_delay + 1) begin
            tick;
            tx_done = 1'b0;
            check("busy_wait", {31'd0, busy}, 1);
            check("tx_start_once", {31'd0, tx_start}, 0);
        end
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
        check("busy_after_done", {31'd0, busy}, 0);
        check("timeout_err_quiet", {31'd0, timeout_err}, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (grant != 4'b0000) begin
                if (sb.size() == 0) check("grant_unexpected", {28'd0, grant}, 0);
                else check("sb_grant", {28'd0, grant}, 32'(1) << sb[0].owner);
            end
            if (tx_start) begin
                if (sb.size() == 0) begin
                    check("tx_start_unexpected", {31'd0, tx_start}, 0);
                end else begin
                    e = sb.pop_front();
                    check("sb_owner", {30'd0, owner}, e.owner);
                    check("sb_tx_data", {24'd0, tx_data}, {24'd0, e.data});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        req_data = {8'h3C, 8'hA5, 8'h5A, 8'hC3};
        repeat (3) tick;
        check("rst_grant", {28'd0, grant}, 0);
        check("rst_tx_start", {31'd0, tx_start}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_owner", {30'd0, owner}, 0);
        check("rst_tx_data", {24'd0, tx_data}, 0);
        check("rst_timeout_err", {31'd0, timeout_err}, 0);
        rst = 1'b1;
        tick;

        // Single request, tx_done five cycles after tx_start
        req = 4'b0100;
        push(2);
        xfer(2, 4'b0000, req_data, 4, 1'b0);
        check("tx_data_hold", {24'd0, tx_data}, 32'hA5);

        // Reset while requester 3 is in WAIT; rr_ptr was 3 before reset
        req = 4'b1000;
        push(3);
        tick;
        req = 4'b0000;
        tick;
        tick;
        check("owner_wait", {30'd0, owner}, 3);
        check("busy_wait_pre_rst", {31'd0, busy}, 1);
        rst = 1'b0;
        #1;
        check("arst_grant", {28'd0, grant}, 0);
        check("arst_tx_start", {31'd0, tx_start}, 0);
        check("arst_busy", {31'd0, busy}, 0);
        check("arst_owner", {30'd0, owner}, 0);
        check("arst_tx_data", {24'd0, tx_data}, 0);
        check("arst_timeout_err", {31'd0, timeout_err}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        req = 4'b1001;
        push(0);
        xfer(0, 4'b1000, req_data, 0, 1'b0);
        push(3);
        xfer(3, 4'b0000, req_data, 0, 1'b0);

        // Fairness: all four held, each re-requests after its grant
        req = 4'b1111;
        for (int i = 0; i < 5; i++) push(i % 4);
        for (int i = 0; i < 5; i++) begin
            xfer(i % 4, (i == 4) ? 4'b0000 : 4'b1111, req_data, 0, 1'b0);
        end

        // Withdraw after capture; the captured word must survive a data change
        req = 4'b0010;
        push(1);
        xfer(1, 4'b0000, {8'h3C, 8'hA5, 8'hFF, 8'hC3}, 2, 1'b0);
        check("withdraw_data", {24'd0, tx_data}, 32'h5A);
        req_data = {8'h3C, 8'hA5, 8'h5A, 8'hC3};

        // Spurious tx_done in IDLE, then in START
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
        check("idle_done_busy", {31'd0, busy}, 0);
        check("idle_done_owner", {30'd0, owner}, 1);
        tick;
        check("idle_done_busy2", {31'd0, busy}, 0);
        req = 4'b0100;
        push(2);
        xfer(2, 4'b0000, req_data, 2, 1'b1);

        // Pointer wrap: rr_ptr is 3, so 3 wins over 0, then 0
        req = 4'b1001;
        push(3);
        push(0);
        xfer(3, 4'b0001, req_data, 0, 1'b0);
        xfer(0, 4'b0000, req_data, 0, 1'b0);

`ifdef UART_ARB_TIMEOUT_EN
        req = 4'b0100;
        push(2);
        tick;
        check("to_grant", {28'd0, grant}, 32'h4);
        req = 4'b0000;
        tick;
        check("to_tx_start", {31'd0, tx_start}, 1);
        n = 0;
        while (busy && n < 40) begin
            tick;
            n++;
        end
        check("timeout_len", n, 17);
        check("timeout_err_pulse", {31'd0, timeout_err}, 1);
        tick;
        check("timeout_err_one", {31'd0, timeout_err}, 0);
        check("timeout_idle", {31'd0, busy}, 0);
        req = 4'b0101;
        push(0);
        xfer(0, 4'b0100, req_data, 0, 1'b0);
        push(2);
        xfer(2, 4'b0000, req_data, 15, 1'b0);
`endif

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
